// File: rtl/mem_seq_pkg.sv
// Shared types for the SRAM access sequencer: FSM states, MDR mux codes, wait bounds
// and the per-state strobe decode used to register the outputs.
package mem_seq_pkg;

    localparam int unsigned WAIT_MIN = 1;
    localparam int unsigned WAIT_MAX = 7;

    localparam logic [1:0] MDR_SEL_BUS = 2'b00;
    localparam logic [1:0] MDR_SEL_MEM = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RD_WAIT,
        RD_LATCH,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic [1:0] mdr_sel;
        logic       ce_n;
        logic       oe_n;
        logic       we_n;
        logic       mem_drive;
        logic       busy;
        logic       done;
    } outs_t;

    // rw only matters in ADDR, where a write also captures the bus into MDR
    function automatic outs_t decode_outs(input state_t s, input logic rw);
        outs_t o;
        o = '{ld_mar: 1'b0, ld_mdr: 1'b0, mdr_sel: MDR_SEL_BUS, ce_n: 1'b1,
               oe_n: 1'b1, we_n: 1'b1, mem_drive: 1'b0, busy: 1'b1, done: 1'b0};
        case (s)
            IDLE:     o.busy = 1'b0;
            ADDR: begin
                o.ld_mar = 1'b1;
                o.ld_mdr = rw;
            end
            RD_WAIT: begin
                o.ce_n = 1'b0;
                o.oe_n = 1'b0;
            end
            RD_LATCH: begin
                o.ce_n    = 1'b0;
                o.oe_n    = 1'b0;
                o.ld_mdr  = 1'b1;
                o.mdr_sel = MDR_SEL_MEM;
            end
            WR_SETUP, WR_HOLD: begin
                o.ce_n      = 1'b0;
                o.mem_drive = 1'b1;
            end
            WR_PULSE: begin
                o.ce_n      = 1'b0;
                o.we_n      = 1'b0;
                o.mem_drive = 1'b1;
            end
            DONE:     o.done = 1'b1;
            default:  o.busy = 1'b0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mem_seq_wait_cnt.sv
// Wait-state down-counter: load a 3-bit value, decrement to zero, flag when zero.
// Zero flag is a register decode, no extra latency; no backpressure.
module mem_wait_cnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [2:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 3'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != 3'd0)) begin
            cnt <= cnt - 3'd1;
        end
    end

    assign zero = (cnt == 3'd0);

endmodule

// File: rtl/mem_sequencer.sv
// SRAM access sequencer: one read or write per Req, strobes registered from next state.
// Read Done in cycle WAIT_CYCLES+3, write Done in WAIT_CYCLES+4; Req ignored while Busy.
// MEM_SEQ_CNT_EN adds saturating Rd_count/Wr_count completion counters.
module mem_sequencer
    import mem_seq_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        Rw,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic [1:0]  MDR_sel,
    output logic        CE_N,
    output logic        OE_N,
    output logic        WE_N,
    output logic        Mem_drive,
    output logic        Busy,
    output logic        Done
`ifdef MEM_SEQ_CNT_EN
    ,
    output logic [15:0] Rd_count,
    output logic [15:0] Wr_count
`endif
);

    // Counter is loaded with WAIT_CYCLES-1 so the wait state lasts exactly WAIT_CYCLES
    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES - 1);

    state_t state, nxt;
    logic   rw_q, rw_nxt;
    logic   cnt_load, cnt_dec, cnt_zero;
    outs_t  outs;

    mem_wait_cnt u_wait_cnt (
        .clk      (Clk),
        .reset    (Reset),
        .load     (cnt_load),
        .load_val (WAIT_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        nxt      = state;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        rw_nxt   = (state == IDLE) ? Rw : rw_q;
        case (state)
            IDLE:     if (Req) nxt = ADDR;
            ADDR: begin
                nxt      = rw_q ? WR_SETUP : RD_WAIT;
                cnt_load = !rw_q;
            end
            RD_WAIT: begin
                if (cnt_zero) nxt = RD_LATCH;
                else          cnt_dec = 1'b1;
            end
            RD_LATCH: nxt = DONE;
            WR_SETUP: begin
                nxt      = WR_PULSE;
                cnt_load = 1'b1;
            end
            WR_PULSE: begin
                if (cnt_zero) nxt = WR_HOLD;
                else          cnt_dec = 1'b1;
            end
            WR_HOLD:  nxt = DONE;
            DONE:     nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            rw_q  <= 1'b0;
            outs  <= decode_outs(IDLE, 1'b0);
        end else begin
            state <= nxt;
            if (state == IDLE && Req) rw_q <= Rw;
            outs  <= decode_outs(nxt, rw_nxt);
        end
    end

    assign LD_MAR    = outs.ld_mar;
    assign LD_MDR    = outs.ld_mdr;
    assign MDR_sel   = outs.mdr_sel;
    assign CE_N      = outs.ce_n;
    assign OE_N      = outs.oe_n;
    assign WE_N      = outs.we_n;
    assign Mem_drive = outs.mem_drive;
    assign Busy      = outs.busy;
    assign Done      = outs.done;

`ifdef MEM_SEQ_CNT_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Rd_count <= 16'd0;
            Wr_count <= 16'd0;
        end else if (state == DONE) begin
            if (rw_q && (Wr_count != 16'hFFFF))  Wr_count <= Wr_count + 16'd1;
            if (!rw_q && (Rd_count != 16'hFFFF)) Rd_count <= Rd_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_sequencer.sv
// Drives three sequencers (WAIT_CYCLES 1, 2, 7) with shared directed + random stimulus
// and checks every output every cycle against a phase-based access model.
module tb_mem_sequencer;

    localparam int N = 3;
    localparam int WV [N] = '{1, 2, 7};

    logic Clk = 1'b0;
    logic Reset, Req, Rw;
    always #5 Clk = ~Clk;

    logic [9:0]  obs [N];
`ifdef MEM_SEQ_CNT_EN
    logic [15:0] rdc [N];
    logic [15:0] wrc [N];
`endif

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic       ld_mar, ld_mdr, ce_n, oe_n, we_n, mem_drive, busy, done;
        logic [1:0] mdr_sel;
        mem_sequencer #(.WAIT_CYCLES(WV[g])) u_dut (
            .Clk       (Clk),
            .Reset     (Reset),
            .Req       (Req),
            .Rw        (Rw),
            .LD_MAR    (ld_mar),
            .LD_MDR    (ld_mdr),
            .MDR_sel   (mdr_sel),
            .CE_N      (ce_n),
            .OE_N      (oe_n),
            .WE_N      (we_n),
            .Mem_drive (mem_drive),
            .Busy      (busy),
            .Done      (done)
`ifdef MEM_SEQ_CNT_EN
            ,
            .Rd_count  (rdc[g]),
            .Wr_count  (wrc[g])
`endif
        );
        assign obs[g] = {ld_mar, ld_mdr, mdr_sel, ce_n, oe_n, we_n, mem_drive, busy, done};
    end

    // Reference model: an access is just its type and the cycle number k within it
    bit act [N];
    bit mrw [N];
    int k   [N];
    int rdm [N];
    int wrm [N];

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int acc_len(input bit rw, input int w);
        return rw ? w + 4 : w + 3;
    endfunction

    function automatic logic [9:0] expect_out(input bit a, input int kk, input bit rw, input int w);
        logic ld_mar, ld_mdr, ce_n, oe_n, we_n, md, done;
        logic [1:0] sel;
        if (!a) return {1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        ld_mar = (kk == 1);
        if (!rw) begin
            ld_mdr = (kk == w + 2);
            sel    = (kk == w + 2) ? 2'b01 : 2'b00;
            ce_n   = !(kk >= 2 && kk <= w + 2);
            oe_n   = ce_n;
            we_n   = 1'b1;
            md     = 1'b0;
        end else begin
            ld_mdr = (kk == 1);
            sel    = 2'b00;
            ce_n   = !(kk >= 2 && kk <= w + 3);
            oe_n   = 1'b1;
            we_n   = !(kk >= 3 && kk <= w + 2);
            md     = (kk >= 2 && kk <= w + 3);
        end
        done = (kk == acc_len(rw, w));
        return {ld_mar, ld_mdr, sel, ce_n, oe_n, we_n, md, 1'b1, done};
    endfunction

    task automatic step(input bit rst, input bit rq, input bit r);
        Reset = rst;
        Req   = rq;
        Rw    = r;
        @(posedge Clk);
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                act[i] = 1'b0;
                rdm[i] = 0;
                wrm[i] = 0;
            end else if (act[i]) begin
                if (k[i] == acc_len(mrw[i], WV[i])) begin
                    act[i] = 1'b0;
                    if (mrw[i]) wrm[i] = (wrm[i] == 65535) ? 65535 : wrm[i] + 1;
                    else        rdm[i] = (rdm[i] == 65535) ? 65535 : rdm[i] + 1;
                end else begin
                    k[i]++;
                end
            end else if (rq) begin
                act[i] = 1'b1;
                k[i]   = 1;
                mrw[i] = r;
            end
        end
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("w%0d_outputs", WV[i]), 16'(obs[i]),
                16'(expect_out(act[i], k[i], mrw[i], WV[i])));
            chk($sformatf("w%0d_strobe_rules", WV[i]),
                16'({obs[i][4] | obs[i][3], obs[i][3] | obs[i][2],
                     obs[i][8] | (obs[i][7:6] == 2'b00)}), 16'h0007);
`ifdef MEM_SEQ_CNT_EN
            chk($sformatf("w%0d_rd_count", WV[i]), rdc[i], 16'(rdm[i]));
            chk($sformatf("w%0d_wr_count", WV[i]), wrc[i], 16'(wrm[i]));
`endif
        end
    endtask

    initial begin
        Reset = 1'b1;
        Req   = 1'b0;
        Rw    = 1'b0;
        for (int i = 0; i < N; i++) begin
            act[i] = 1'b0; mrw[i] = 1'b0; k[i] = 0; rdm[i] = 0; wrm[i] = 0;
        end

        // reset, then reset winning over a simultaneous request
        step(1, 0, 0);
        step(1, 1, 1);

        // single read, Rw wiggling while busy
        step(0, 1, 0);
        repeat (12) step(0, 0, 1'($urandom_range(0, 1)));

        // single write
        step(0, 1, 1);
        repeat (12) step(0, 0, 0);

        // Req held high: back-to-back reads with one idle cycle between
        repeat (20) step(0, 1, 0);
        repeat (12) step(0, 0, 0);

        // Req held with Rw toggling mid-access
        repeat (24) step(0, 1, 1'($urandom_range(0, 1)));
        repeat (12) step(0, 0, 0);

        // 3 reads + 2 writes for the completion counters
        for (int j = 0; j < 5; j++) begin
            step(0, 1, (j >= 3));
            repeat (11) step(0, 0, 0);
        end

        // reset during cycle 3 of a write aborts without Done
        step(0, 1, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        repeat (3) step(0, 0, 0);

        // random traffic with occasional resets
        repeat (500) step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
        repeat (12) step(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
